// File: rtl/debounce_multicanal_if.sv
// -----------------------------------------------------------------------------
// debounce_multicanal_if
//   Bundle of the per-channel key signals exchanged between the key source
//   (board/testbench) and the debouncer.
//   chave   : raw asynchronous key inputs (master -> slave)
//   sinal   : debounced level, 1 = pressed (slave -> master)
//   subida  : one-cycle pulse, press accepted
//   descida : one-cycle pulse, release accepted
//   evento  : one-cycle pulse, press or auto-repeat
// -----------------------------------------------------------------------------
interface debounce_multicanal_if #(
    parameter int N_CANAIS = 4
);
    logic [N_CANAIS-1:0] chave;
    logic [N_CANAIS-1:0] sinal;
    logic [N_CANAIS-1:0] subida;
    logic [N_CANAIS-1:0] descida;
    logic [N_CANAIS-1:0] evento;

    modport master (
        output chave,
        input  sinal,
        input  subida,
        input  descida,
        input  evento
    );

    modport slave (
        input  chave,
        output sinal,
        output subida,
        output descida,
        output evento
    );
endinterface

// File: rtl/debounce_multicanal.sv
// -----------------------------------------------------------------------------
// debounce_multicanal
//   N-channel key debouncer: per channel a 2-FF synchroniser, a stability
//   counter that accepts a new level only after DEBOUNCE_CYC consecutive
//   cycles, registered press/release pulses and optional auto-repeat on evento.
// Ports
//   clk   : system clock, all logic on posedge
//   rst_n : synchronous reset, active-low
//   bus   : debounce_multicanal_if.slave (chave in; sinal/subida/descida/evento out)
//
// Repeat phase (per channel)
//   state      | meaning
//   FASE_DELAY | waiting REPEAT_DELAY cycles after the accepted press
//   FASE_RATE  | emitting a repeat every REPEAT_RATE cycles
// -----------------------------------------------------------------------------
module debounce_multicanal #(
    parameter int N_CANAIS     = 4,
    parameter int DEBOUNCE_CYC = 140000,
    parameter int ATIVO_BAIXO  = 0,
    parameter int REPEAT_EN    = 0,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input logic                  clk,
    input logic                  rst_n,
    debounce_multicanal_if.slave bus
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(DEBOUNCE_CYC + 1);
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0] DEB_TC  = CW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] DLY_TC  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_TC = RW'(REPEAT_RATE - 1);
    localparam logic          INV     = (ATIVO_BAIXO != 0);
    localparam logic          REP     = (REPEAT_EN != 0);

    typedef enum logic {
        FASE_DELAY = 1'b0,
        FASE_RATE  = 1'b1
    } fase_t;

    logic [N_CANAIS-1:0] p;
    logic [N_CANAIS-1:0] sinal_v;
    logic [N_CANAIS-1:0] subida_v;
    logic [N_CANAIS-1:0] descida_v;
    logic [N_CANAIS-1:0] evento_v;

    // Polarity correction: from here on 1 always means pressed.
    assign p = bus.chave ^ {N_CANAIS{INV}};

    for (genvar g = 0; g < N_CANAIS; g++) begin : g_canal
        logic          s1_q;
        logic          s2_q;
        logic          sinal_q;
        logic          subida_q;
        logic          descida_q;
        logic          evento_q;
        logic [CW-1:0] cnt_q;
        logic [RW-1:0] rcnt_q;
        fase_t         fase_q;
        logic          aceita;
        logic          rep_tc;

        // New level has been stable long enough: it is taken on this edge.
        assign aceita = (s2_q != sinal_q) && (cnt_q == DEB_TC);
        assign rep_tc = (fase_q == FASE_DELAY) ? (rcnt_q == DLY_TC) : (rcnt_q == RATE_TC);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_q      <= 1'b0;
                s2_q      <= 1'b0;
                sinal_q   <= 1'b0;
                subida_q  <= 1'b0;
                descida_q <= 1'b0;
                evento_q  <= 1'b0;
                cnt_q     <= '0;
                rcnt_q    <= '0;
                fase_q    <= FASE_DELAY;
            end else begin
                s1_q      <= p[g];
                s2_q      <= s1_q;
                subida_q  <= 1'b0;
                descida_q <= 1'b0;
                evento_q  <= 1'b0;

                // Any return to the current level restarts the stability count.
                if (s2_q == sinal_q) begin
                    cnt_q <= '0;
                end else if (aceita) begin
                    sinal_q   <= s2_q;
                    cnt_q     <= '0;
                    subida_q  <= s2_q;
                    descida_q <= ~s2_q;
                    evento_q  <= s2_q;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end

                // Accepting a release on a would-be repeat edge suppresses the
                // repeat; accepting a press restarts the delay phase.
                if (!REP || !sinal_q || aceita) begin
                    rcnt_q <= '0;
                    fase_q <= FASE_DELAY;
                end else if (rep_tc) begin
                    evento_q <= 1'b1;
                    rcnt_q   <= '0;
                    fase_q   <= FASE_RATE;
                end else begin
                    rcnt_q <= rcnt_q + RW'(1);
                end
            end
        end

        assign sinal_v[g]   = sinal_q;
        assign subida_v[g]  = subida_q;
        assign descida_v[g] = descida_q;
        assign evento_v[g]  = evento_q;
    end

    assign bus.sinal   = sinal_v;
    assign bus.subida  = subida_v;
    assign bus.descida = descida_v;
    assign bus.evento  = evento_v;

endmodule
